// File: rtl/ms2xs_pkg.sv
// ms2xs_pkg: width helpers and FSM encoding shared by the ms2xs sequencer
package ms2xs_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;
  // bits needed to hold the value x, never less than one
  function automatic int clog2(input int x);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) <= x) r = i + 1;
    return r;
  endfunction
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic int addr_w(input int n);
    return clog2(n - 1);
  endfunction
  function automatic int blk_w(input int n, input int m);
    return clog2(ceil_div(n, m) - 1);
  endfunction
endpackage

// File: rtl/ms2xs_lane_addr.sv
// ms2xs_lane_addr: one lane's h index, valid and negate flags for row j, block k
module ms2xs_lane_addr
  import ms2xs_pkg::*;
#(
  parameter int N       = 541,
  parameter int M       = 1,
  parameter int L       = 0,
  parameter int NEGACYC = 0,
  parameter int AW      = addr_w(541),
  parameter int EW      = blk_w(541, 1)
) (
  input  logic          run,
  input  logic [AW-1:0] j,
  input  logic [EW-1:0] k,
  output logic [AW-1:0] addr_h,
  output logic          vld,
  output logic          neg
);
  logic [AW:0] e, d;
  logic in_rng, wrap, unused_msb;
  // k*M+l never exceeds 2N-3, so AW+1 bits hold it and e+N without overflow
  assign e = (AW+1)'(k) * (AW+1)'(M) + (AW+1)'(L);
  assign in_rng = e < (AW+1)'(N);
  assign wrap = e < {1'b0, j};
  assign d = wrap ? e + (AW+1)'(N) - {1'b0, j} : e - {1'b0, j};
  assign unused_msb = d[AW];
  assign vld = run && in_rng;
  assign neg = (NEGACYC != 0) && vld && wrap;
  assign addr_h = vld ? d[AW-1:0] : '0;
endmodule

// File: rtl/ms2xs_mult_seq.sv
// ms2xs_mult_seq: row/block sequencer for a polynomial multiplier; MS2XS_ZERO_SKIP_EN skips zero r rows
module ms2xs_mult_seq
  import ms2xs_pkg::*;
#(
  parameter int N       = 541,
  parameter int Q       = 2048,
  parameter int M       = 1,
  parameter int RD_LAT  = 1,
  parameter int NEGACYC = 0,
  localparam int QW = clog2(Q - 1),
  localparam int AW = addr_w(N),
  localparam int K  = ceil_div(N, M),
  localparam int EW = blk_w(N, M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [QW-1:0]   r_coef,
  output logic [AW-1:0]   addr_r,
  output logic [EW-1:0]   addr_e,
  output logic [M*AW-1:0] addr_h,
  output logic [M-1:0]    lane_vld,
  output logic [M-1:0]    lane_neg,
  output logic            operate,
  output logic            busy,
  output logic            done,
  output logic            end_op
`ifdef MS2XS_ZERO_SKIP_EN
  ,
  output logic [clog2(N)-1:0] nz_cnt
`endif
);
  localparam int DW = clog2(RD_LAT);
  state_t state;
  logic [AW-1:0] j;
  logic [EW-1:0] k;
  logic [DW-1:0] cnt;
  logic last_k, last_j, run_st;
  assign last_k = k == EW'(K - 1);
  assign last_j = j == AW'(N - 1);
  assign run_st = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign addr_r = j;
  assign addr_e = k;
`ifdef MS2XS_ZERO_SKIP_EN
  logic skip;
  // r_coef for row j is valid from the first RUN cycle; a zero row ends right there
  assign skip = run_st && k == '0 && r_coef == '0;
  assign operate = run_st && !skip;
  localparam int NZW = clog2(N);
  always_ff @(posedge clk) begin
    if (!rst) nz_cnt <= '0;
    else if (state == IDLE && start) nz_cnt <= '0;
    else if (operate && k == '0) nz_cnt <= nz_cnt + NZW'(1);
  end
`else
  logic unused_r;
  assign unused_r = ^r_coef;
  assign operate = run_st;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      j <= '0;
      k <= '0;
      cnt <= '0;
      end_op <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
`ifdef MS2XS_ZERO_SKIP_EN
          state <= FETCH;
`else
          state <= RUN;
`endif
          j <= '0;
          k <= '0;
          cnt <= '0;
          end_op <= 1'b0;
        end
`ifdef MS2XS_ZERO_SKIP_EN
        FETCH: begin
          cnt <= cnt == DW'(RD_LAT - 1) ? '0 : cnt + DW'(1);
          if (cnt == DW'(RD_LAT - 1)) state <= RUN;
        end
        RUN: if (skip || last_k) begin
          k <= '0;
          j <= last_j ? j : j + AW'(1);
          state <= last_j ? DRAIN : FETCH;
        end else begin
          k <= k + EW'(1);
        end
`else
        RUN: if (last_k) begin
          k <= '0;
          j <= last_j ? j : j + AW'(1);
          if (last_j) state <= DRAIN;
        end else begin
          k <= k + EW'(1);
        end
`endif
        DRAIN: begin
          cnt <= cnt == DW'(RD_LAT) ? '0 : cnt + DW'(1);
          if (cnt == DW'(RD_LAT)) begin
            state <= DONE;
            end_op <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          j <= '0;
          k <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar l = 0; l < M; l++) begin : g_lane
    ms2xs_lane_addr #(
      .N(N), .M(M), .L(l), .NEGACYC(NEGACYC), .AW(AW), .EW(EW)
    ) u_lane (
      .run(operate),
      .j(j),
      .k(k),
      .addr_h(addr_h[l*AW +: AW]),
      .vld(lane_vld[l]),
      .neg(lane_neg[l])
    );
  end
endmodule

// File: tb/tb_ms2xs_mult_seq.sv
// tb_ms2xs_mult_seq: scoreboard bench for ms2xs_mult_seq (N=7; M=1, M=3 and negacyclic instances)
module tb_ms2xs_mult_seq;
  localparam int N = 7, RL = 1, K0 = 7, K1 = 3;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [10:0] r_coef = '0;
  logic [2:0] a_r0, a_r1, a_r2, a_e0, a_e2, a_h0, a_h2, v1, n1;
  logic [1:0] a_e1;
  logic [8:0] a_h1;
  logic v0, n0, v2, n2, op0, op1, op2, b0, b1, b2, d0, d1, d2, eo0, eo1, eo2;
`ifdef MS2XS_ZERO_SKIP_EN
  logic [2:0] nz0, nz1, nz2;
`endif
  int tests = 0, fails = 0;
  int q0[$], q1[$];
  always #5 clk = ~clk;

  ms2xs_mult_seq #(.N(7), .M(1), .RD_LAT(1), .NEGACYC(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .r_coef(r_coef), .addr_r(a_r0), .addr_e(a_e0),
    .addr_h(a_h0), .lane_vld(v0), .lane_neg(n0), .operate(op0), .busy(b0), .done(d0), .end_op(eo0)
`ifdef MS2XS_ZERO_SKIP_EN
    , .nz_cnt(nz0)
`endif
  );
  ms2xs_mult_seq #(.N(7), .M(3), .RD_LAT(1), .NEGACYC(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .r_coef(r_coef), .addr_r(a_r1), .addr_e(a_e1),
    .addr_h(a_h1), .lane_vld(v1), .lane_neg(n1), .operate(op1), .busy(b1), .done(d1), .end_op(eo1)
`ifdef MS2XS_ZERO_SKIP_EN
    , .nz_cnt(nz1)
`endif
  );
  ms2xs_mult_seq #(.N(7), .M(1), .RD_LAT(1), .NEGACYC(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .r_coef(r_coef), .addr_r(a_r2), .addr_e(a_e2),
    .addr_h(a_h2), .lane_vld(v2), .lane_neg(n2), .operate(op2), .busy(b2), .done(d2), .end_op(eo2)
`ifdef MS2XS_ZERO_SKIP_EN
    , .nz_cnt(nz2)
`endif
  );

  function automatic void lane_exp(input int m, input int neg, input int j, input int k, input int l,
                                   output int h, output bit v, output bit ng);
    int e;
    e = k * m + l;
    v = e < N;
    h = v ? ((e - j) % N + N) % N : 0;
    ng = v && neg != 0 && e < j;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_r0, a_e0, a_h0, v0, n0, op0, b0, d0, eo0} !== 17'b0) begin
      fails++; $display("FAIL reset_u0 got %h want 0", {a_r0, a_e0, a_h0, v0, n0, op0, b0, d0, eo0});
    end
    tests++;
    if ({a_r1, a_e1, a_h1, v1, n1, op1, b1, d1, eo1} !== 24'b0) begin
      fails++; $display("FAIL reset_u1 got %h want 0", {a_r1, a_e1, a_h1, v1, n1, op1, b1, d1, eo1});
    end
    tests++;
    if ({a_r2, a_e2, a_h2, v2, n2, op2, b2, d2, eo2} !== 17'b0) begin
      fails++; $display("FAIL reset_u2 got %h want 0", {a_r2, a_e2, a_h2, v2, n2, op2, b2, d2, eo2});
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({b0, b1, b2} !== 3'b0) begin
      fails++; $display("FAIL idle_after_reset busy got %b want 000", {b0, b1, b2});
    end
  endtask

`ifndef MS2XS_ZERO_SKIP_EN
  task automatic run_op(input int pulse_at, input int len);
    int done0, done1, nd0, h, j, k, exp_lat;
    bit v, ng;
    done0 = -1;
    done1 = -1;
    nd0 = 0;
    q0.push_back(N * K0 + RL + 2);
    q1.push_back(N * K1 + RL + 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < len; t++) begin
      tests++;
      if (op0 !== (t < N * K0)) begin
        fails++; $display("FAIL operate t=%0d got %b want %b", t, op0, t < N * K0);
      end
      if (t < N * K0) begin
        j = t / K0;
        k = t % K0;
        lane_exp(1, 0, j, k, 0, h, v, ng);
        tests++;
        if ({a_r0, a_e0, a_h0, v0, n0} !== {3'(j), 3'(k), 3'(h), v, ng}) begin
          fails++; $display("FAIL u0_lane t=%0d got %b want %b", t, {a_r0, a_e0, a_h0, v0, n0},
                            {3'(j), 3'(k), 3'(h), v, ng});
        end
        lane_exp(1, 1, j, k, 0, h, v, ng);
        tests++;
        if ({a_r2, a_e2, a_h2, v2, n2} !== {3'(j), 3'(k), 3'(h), v, ng}) begin
          fails++; $display("FAIL u2_negacyc t=%0d got %b want %b", t, {a_r2, a_e2, a_h2, v2, n2},
                            {3'(j), 3'(k), 3'(h), v, ng});
        end
      end else begin
        tests++;
        if ({v0, n0, v2, n2, op2} !== 5'b0) begin
          fails++; $display("FAIL lanes_off t=%0d got %b want 00000", t, {v0, n0, v2, n2, op2});
        end
      end
      if (t < N * K1) begin
        j = t / K1;
        k = t % K1;
        tests++;
        if ({a_r1, a_e1} !== {3'(j), 2'(k)}) begin
          fails++; $display("FAIL u1_jk t=%0d got %b want %b", t, {a_r1, a_e1}, {3'(j), 2'(k)});
        end
        for (int l = 0; l < 3; l++) begin
          lane_exp(3, 0, j, k, l, h, v, ng);
          tests++;
          if ({a_h1[l*3 +: 3], v1[l], n1[l]} !== {3'(h), v, ng}) begin
            fails++; $display("FAIL u1_lane%0d t=%0d got %b want %b", l, t,
                              {a_h1[l*3 +: 3], v1[l], n1[l]}, {3'(h), v, ng});
          end
        end
      end else begin
        tests++;
        if ({v1, n1, op1} !== 7'b0) begin
          fails++; $display("FAIL u1_lanes_off t=%0d got %b want 0", t, {v1, n1, op1});
        end
      end
      if (t == 2) begin
        tests++;
        if (v1 !== 3'b001) begin
          fails++; $display("FAIL u1_vld_k2 got %b want 001", v1);
        end
      end
      if (t == 9) begin
        tests++;
        if (a_h1[5:3] !== 3'd5) begin
          fails++; $display("FAIL u1_lane1_j3k0 got %0d want 5", a_h1[5:3]);
        end
      end
      if (t == 22) begin
        tests++;
        if ({a_h2, n2} !== {3'd5, 1'b1}) begin
          fails++; $display("FAIL neg_j3k1 got h=%0d neg=%b want h=5 neg=1", a_h2, n2);
        end
      end
      if (t == 25) begin
        tests++;
        if ({a_h2, n2} !== {3'd1, 1'b0}) begin
          fails++; $display("FAIL neg_j3k4 got h=%0d neg=%b want h=1 neg=0", a_h2, n2);
        end
      end
      tests++;
      if (b0 !== (t <= N * K0 + RL + 1)) begin
        fails++; $display("FAIL busy t=%0d got %b want %b", t, b0, t <= N * K0 + RL + 1);
      end
      tests++;
      if (eo0 !== (t >= N * K0 + RL + 1)) begin
        fails++; $display("FAIL end_op t=%0d got %b want %b", t, eo0, t >= N * K0 + RL + 1);
      end
      if (d0 === 1'b1) begin
        nd0++;
        if (done0 < 0) done0 = t;
      end
      if (d1 === 1'b1 && done1 < 0) done1 = t;
      start = (t == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (nd0 != 1) begin
      fails++; $display("FAIL done_pulses got %0d want 1", nd0);
    end
    exp_lat = q0.pop_front();
    tests++;
    if (done0 + 1 != exp_lat) begin
      fails++; $display("FAIL latency_u0 got %0d want %0d", done0 + 1, exp_lat);
    end
    exp_lat = q1.pop_front();
    tests++;
    if (done1 + 1 != exp_lat) begin
      fails++; $display("FAIL latency_u1 got %0d want %0d", done1 + 1, exp_lat);
    end
  endtask

  task automatic test_basic();
    run_op(-1, 70);
  endtask

  task automatic test_start_ignored();
    run_op(10, 70);
  endtask

  task automatic test_back_to_back();
    run_op(-1, N * K0 + RL + 2);
    run_op(-1, 70);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * K0) @(negedge clk);
    tests++;
    if ({a_r0, a_e0} !== {3'd3, 3'd0}) begin
      fails++; $display("FAIL pre_reset_jk got %b want 011000", {a_r0, a_e0});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({a_r0, a_e0, a_h0, v0, n0, op0, b0, d0, eo0} !== 17'b0) begin
      fails++; $display("FAIL midreset_u0 got %h want 0", {a_r0, a_e0, a_h0, v0, n0, op0, b0, d0, eo0});
    end
    tests++;
    if ({a_r2, a_h2, n2, op2, b2, b1, op1, v1} !== 13'b0) begin
      fails++; $display("FAIL midreset_u1u2 got %h want 0", {a_r2, a_h2, n2, op2, b2, b1, op1, v1});
    end
    rst = 1'b1;
    @(negedge clk);
    run_op(-1, 70);
  endtask
`else
  task automatic test_zero_skip();
    int ops, done0, exp_lat;
    logic [2:0] ap;
    ops = 0;
    done0 = -1;
    ap = a_r0;
    q0.push_back(23);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 60 && done0 < 0; t++) begin
      r_coef = (ap == 3'd2) ? 11'd5 : 11'd0;
      ap = a_r0;
      #1;
      if (op0 === 1'b1) begin
        ops++;
        tests++;
        if (a_r0 !== 3'd2) begin
          fails++; $display("FAIL zs_row t=%0d got %0d want 2", t, a_r0);
        end
      end
      if (d0 === 1'b1) done0 = t;
      @(negedge clk);
    end
    r_coef = '0;
    tests++;
    if (ops != 7) begin
      fails++; $display("FAIL zs_operate_cycles got %0d want 7", ops);
    end
    tests++;
    if (nz0 !== 3'd1) begin
      fails++; $display("FAIL zs_nz_cnt got %0d want 1", nz0);
    end
    exp_lat = q0.pop_front();
    tests++;
    if (done0 + 1 != exp_lat) begin
      fails++; $display("FAIL zs_latency got %0d want %0d", done0 + 1, exp_lat);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MS2XS_ZERO_SKIP_EN
    test_zero_skip();
`else
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
